// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first), writes them to
// instruction memory from address 0, checks a trailing XOR checksum and gates the CPU reset.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_LEN_HI  | waiting for word-count high byte
// S_LEN_LO  | waiting for word-count low byte, range check
// S_DATA_HI | waiting for instruction high byte
// S_DATA_LO | waiting for instruction low byte, issue write
// S_CHK     | waiting for checksum byte
// S_DONE    | load good, CPU released (terminal)
// S_ERR     | load aborted, CPU held (terminal)
module prog_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [15:0]       mem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [15:0]       n_new;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_ad_q, mem_ad_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  // Terminal states refuse bytes; the reset term keeps ready low in the reset cycle itself.
  assign in_ready = !reset && (state_q != S_DONE) && (state_q != S_ERR);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 1'b1;
  assign n_new    = {len_q[15:8], in_data};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    chk_d       = chk_q;
    cnt_d       = cnt_q;
    mem_wr_d    = 1'b0;
    mem_ad_d    = mem_ad_q;
    mem_data_d  = mem_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
    if (accept) begin
      chk_d = chk_q ^ in_data;
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = in_data;
          if ({1'b0, n_new} > MAX_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_new == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          hi_d    = in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          mem_wr_d   = 1'b1;
          mem_ad_d   = cnt_q[ADDR_W-1:0];
          mem_data_d = {hi_q, in_data};
          cnt_d      = cnt_inc;
          state_d    = (16'(cnt_inc) == len_q) ? S_CHK : S_DATA_HI;
        end
        S_CHK: begin
          if (in_data == chk_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      len_q       <= '0;
      hi_q        <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      mem_wr_q    <= 1'b0;
      mem_ad_q    <= '0;
      mem_data_q  <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      chk_q       <= chk_d;
      cnt_q       <= cnt_d;
      mem_wr_q    <= mem_wr_d;
      mem_ad_q    <= mem_ad_d;
      mem_data_q  <= mem_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_wr    = mem_wr_q;
  assign mem_ad    = mem_ad_q;
  assign mem_data  = mem_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream loader for the accumulator CPU.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes the words into instruction memory at sequential addresses from 0, then verifies an XOR checksum.
- Holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_W, 12, instruction address width; matches the CPU's 12-bit instruction address field.
- MAX_WORDS, 4096, largest accepted word count; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_wr  output  1  one-cycle write strobe to instruction memory.
- mem_ad  output  ADDR_W  instruction memory write address.
- mem_data  output  16  instruction word to write.
- cpu_reset  output  1  reset to the CPU; high until a load completes.
- done  output  1  load finished and checksum matched.
- err  output  1  load aborted: bad length or checksum mismatch.

Behaviour:
- Stream format: LEN_HI, LEN_LO (N, 16-bit word count), then N×(WORD_HI, WORD_LO), then CHK.
  - CHK = XOR of every preceding byte, including both length bytes.
- A byte is accepted on a rising edge where in_valid && in_ready. No byte is consumed otherwise. in_valid may drop at any time.
- Reset (sync, high):
  - state=S_LEN_HI; in_ready=0 during reset cycle; mem_wr=0; mem_ad=0; mem_data=0; done=0; err=0; cpu_reset=1.
  - Internal checksum accumulator and word counter are cleared.
- in_ready is 1 in S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK; 0 in S_DONE, S_ERR.
- FSM, advancing only on accepted bytes:
  - S_LEN_HI: latch len[15:8] → S_LEN_LO.
  - S_LEN_LO: latch len[7:0].
    - N > MAX_WORDS → S_ERR.
    - N == 0 → S_CHK.
    - Otherwise → S_DATA_HI.
  - S_DATA_HI: latch hi byte → S_DATA_LO.
  - S_DATA_LO: register mem_data={hi,byte} and mem_ad=word counter; assert mem_wr for exactly the next cycle; increment counter.
    - Counter == N after increment → S_CHK.
    - Otherwise → S_DATA_HI.
  - S_CHK: compare byte with running XOR.
    - Equal → S_DONE.
    - Otherwise → S_ERR.
  - S_DONE: done=1, cpu_reset=0; stays here until reset.
  - S_ERR: err=1, cpu_reset=1; stays here until reset.
- Latency and timing:
  - mem_wr is high the cycle after the WORD_LO accept; mem_ad and mem_data are valid in that same cycle.
  - Back-to-back bytes give at most one write every 2 cycles.
  - done/err and cpu_reset change the cycle after the CHK accept (registered).
- Word counter is ADDR_W+1 bits wide, so N=4096 writes addresses 0..4095 with no wrap. mem_ad never exceeds N-1.
- done and err are never high together. cpu_reset == !done at all times after reset.
- Reset mid-load: the FSM restarts at S_LEN_HI. Already-written memory contents are left as-is, with no further mem_wr. cpu_reset stays high.
- in_valid held high in S_DONE/S_ERR: ignored, no state change.

Test Plan:
- Load N=2, words 0x1005, 0x2006, CHK=0x00^0x02^0x10^0x05^0x20^0x06=0x31 → mem_wr pulses at ad 0 (0x1005) then ad 1 (0x2006); done=1; cpu_reset falls the cycle after the CHK byte.
- Same stream with CHK=0x30 → two writes occur, then err=1, done=0, cpu_reset stays 1; further bytes ignored, in_ready=0.
- Header 0x10,0x01 (N=4097) → err=1 the cycle after LEN_LO; no mem_wr ever.
- N=0 (0x00,0x00,CHK=0x00) → no mem_wr; done=1.
- N=2 stream with in_valid toggled randomly (≥30% idle) → identical writes and result to the first test; no byte is duplicated or dropped.
- Assert reset after the first word is written, then send a fresh N=1 stream with word 0xF000 and CHK=0x01^0xF0=0xF1 → single write at ad 0 (0xF000); done=1.
